mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the multicycle control unit; executes the load/store it requests.
- Takes one-cycle load/store strobes plus Size_s/SE_s, generates byte enables and lane-shifted write data, and runs a req/gnt/rvalid handshake to the data bus.
- Aligns and extends read data into the MDR register, which feeds the write-back mux (w_data_s = 2).
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+RESP before the access is aborted. Legal range 1..1023.
- CNT_W, 10: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  reset. One clock; reset is asynchronous and active-low.
- mem_rd  in  1  load request strobe, sampled only in IDLE.
- mem_wr  in  1  store request strobe, sampled only in IDLE.
- addr  in  32  byte address (ALU result F).
- wdata  in  32  store data (rs2).
- Size_s  in  2  00 byte, 01 half, 10 word, 11 illegal.
- SE_s  in  1  0 sign-extend, 1 zero-extend (func3[2]).
- MDR  out  32  registered load result.
- busy  out  1  high in REQ and RESP.
- done  out  1  one-cycle pulse on successful completion.
- misalign  out  1  one-cycle pulse when a request is rejected.
- bus_err  out  1  one-cycle pulse on timeout.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  word address: {addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  bus accepts the request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

Behaviour:
- Reset (rst_ = 0, asynchronous):
  - state goes to IDLE; counter = 0.
  - All outputs go to 0, including MDR.
  - Any transaction in flight is abandoned.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - If mem_wr = 1, store; else if mem_rd = 1, load. Both high means store wins.
  - Illegal request: Size_s = 11, or half with addr[0] = 1, or word with addr[1:0] != 0.
    - misalign = 1 for the next cycle only; stay in IDLE; no bus activity; MDR unchanged.
  - Legal request: latch addr, size, SE_s, offset = addr[1:0] and type, then go to REQ.
    - bus_req and bus_we become valid on the cycle after the strobe.
- Byte enables and write data:
  - byte: be = 4'b0001 << off; wdata[7:0] replicated to all four lanes.
  - half: be = 0011 (off = 0) or 1100 (off = 2); wdata[15:0] replicated twice.
  - word: be = 1111; wdata passed unchanged.
  - bus_be is driven for loads too.
- REQ:
  - bus_req = 1; bus_addr, bus_be, bus_we and bus_wdata are held stable until bus_gnt is sampled high.
  - On gnt: a store goes to DONE; a load goes to RESP.
  - bus_req drops in the cycle after gnt.
- RESP:
  - Wait for bus_rvalid; rvalid seen during REQ is ignored.
  - On rvalid: MDR <= extracted data, then go to DONE.
  - Byte extract: rdata[8*off +: 8]. Half extract: rdata[16*off[1] +: 16].
  - Extension is sign when SE_s = 0, zero when SE_s = 1. Word is passed through.
- DONE:
  - done = 1 for exactly one cycle, then return to IDLE.
  - Strobes seen in REQ, RESP or DONE are ignored; the CU holds no request across states.
- Timeout:
  - counter is cleared on entry to REQ and increments on every cycle spent in REQ or RESP.
  - When counter reaches TIMEOUT with no completing event: bus_err pulses for one cycle, bus_req drops, state goes to IDLE, MDR unchanged, done not asserted.
  - A gnt or rvalid in the same cycle as the timeout completes normally; the timeout does not fire.
- Latency with zero wait states:
  - Store: done is high 2 cycles after the strobe edge.
  - Load: done is high 3 cycles after the strobe edge, and MDR is valid in the same cycle as done.

Test Plan:
- Signed byte load: addr = 0x1003, Size_s = 00, SE_s = 0, rdata = 0x80FF_1234; gnt immediate, rvalid one cycle later -> bus_addr = 0x1000, be = 1000, MDR = 0xFFFF_FF80, done 3 cycles after the strobe.
- Unsigned half load: addr = 0x2002, Size_s = 01, SE_s = 1, rdata = 0xBEEF_0000 -> be = 1100, MDR = 0x0000_BEEF.
- Half store: addr = 0x0006, wdata = 0x1234_ABCD, gnt withheld for 3 cycles -> req held with stable be = 1100 and wdata = 0xABCD_ABCD; done 1 cycle after gnt; bus_we = 1.
- Misalign: word load at 0x0101, then half store at 0x0003 -> misalign pulses each time; bus_req stays 0; MDR unchanged.
- Timeout with TIMEOUT = 4: load issued, gnt given, no rvalid -> bus_err pulses exactly once after 4 cycles in REQ/RESP; done stays 0; state returns to IDLE and the next load completes normally.
- Reset mid-access: assert rst_ = 0 during RESP -> all outputs 0 immediately (asynchronously); a late rvalid after reset release is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// -----------------------------------------------------------------------------
// Data-memory access stage. It executes one load or store at a time on behalf of
// the multicycle control unit and talks to the data bus with a req/gnt/rvalid
// handshake. The unit generates byte enables and lane-replicated store data. It
// also aligns and extends load data into MDR.
//
// Ports
//   clk, rst_              : rising-edge clock, asynchronous active-low reset
//   mem_rd / mem_wr        : one-cycle load / store strobes (only sampled in IDLE)
//   addr, wdata            : byte address and store data
//   Size_s, SE_s           : 00 byte / 01 half / 10 word / 11 illegal;
//                            SE_s = 0 sign-extend, 1 zero-extend
//   MDR                    : registered load result
//   busy, done             : access in progress / one-cycle completion pulse
//   misalign, bus_err      : one-cycle pulses for a rejected request / a timeout
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata : registered bus request side
//   bus_gnt, bus_rvalid, bus_rdata               : bus response side
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 10
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  Size_s,
    input  logic        SE_s,
    output logic [31:0] MDR,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    // Counter value during the last permitted cycle in REQ/RESP.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              se_q, se_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       mdr_q, mdr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;

    logic              req_illegal;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;

    // Request decode, evaluated on the raw inputs while in IDLE.
    always_comb begin
        req_illegal = (Size_s == 2'b11)
                   || ((Size_s == 2'b01) && addr[0])
                   || ((Size_s == 2'b10) && (addr[1:0] != 2'b00));
        case (Size_s)
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Load data alignment uses the offset and size latched at request time.
    always_comb begin
        rd_byte = bus_rdata[{off_q, 3'b000} +: 8];
        rd_half = bus_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = se_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = se_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        se_d        = se_q;
        off_d       = off_q;
        mdr_d       = mdr_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_wr || mem_rd) begin
                    if (req_illegal) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        size_d      = Size_s;
                        se_d        = SE_s;
                        off_d       = addr[1:0];
                        bus_we_d    = mem_wr;   // store wins when both strobes are high
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                    end
                end
            end
            S_REQ: begin
                // A grant in the timeout cycle still completes normally.
                if (bus_gnt) begin
                    state_d = bus_we_q ? S_DONE : S_RESP;
                    cnt_d   = cnt_q + 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    mdr_d   = load_val;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Registered handshake outputs follow the next state.
        bus_req_d = (state_d == S_REQ);
        busy_d    = (state_d == S_REQ) || (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            se_q        <= 1'b0;
            off_q       <= 2'b00;
            mdr_q       <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            se_q        <= se_d;
            off_q       <= off_d;
            mdr_q       <= mdr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign MDR       = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
